// File: rtl/pcie_ats_inval_sched.sv
// ATS invalidation scheduler: queues and coalesces invalidation requests, then
// sequences AFU flush, TX completion and TXREQ completion per entry. Optional macro: PCIE_ATS_INVAL_TIMEOUT_EN.
module pcie_ats_inval_sched #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4:0]               req_itag,
  input  logic [15:0]              req_src_id,
  input  logic [15:0]              req_dst_id,
  input  logic [14:0]              req_func,
  input  logic [2:0]               req_tc,
  output logic                     flush_req,
  output logic [14:0]              flush_func,
  input  logic                     flush_ack,
  output logic                     cpl_tx_valid,
  input  logic                     cpl_tx_ready,
  output logic                     cpl_txreq_valid,
  input  logic                     cpl_txreq_ready,
  output logic [15:0]              cpl_req_id,
  output logic [15:0]              cpl_dst_id,
  output logic [31:0]              cpl_itag_vec,
  output logic [2:0]               cpl_cc,
  output logic [14:0]              cpl_func,
  output logic [2:0]               cpl_tc,
  output logic [$clog2(DEPTH):0]   pending_cnt,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("pcie_ats_inval_sched: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, FLUSH, SEND_TX, SEND_TXREQ} state_t;
  state_t state;

  logic [15:0] src_q  [DEPTH];
  logic [15:0] dst_q  [DEPTH];
  logic [14:0] func_q [DEPTH];
  logic [2:0]  tc_q   [DEPTH];
  logic [31:0] vec_q  [DEPTH];

  logic [AW:0]   head_ptr, tail_ptr;
  logic [AW-1:0] head_idx, tail_idx;
  logic          empty, full, tail_locked, hit, accept, pop, flush_done;
  logic [31:0]   onehot, head_vec;

  assign head_idx    = head_ptr[AW-1:0];
  assign tail_idx    = tail_ptr[AW-1:0] - AW'(1);
  assign empty       = (head_ptr == tail_ptr);
  assign full        = (head_ptr[AW] != tail_ptr[AW]) && (head_ptr[AW-1:0] == tail_ptr[AW-1:0]);
  assign tail_locked = (tail_idx == head_idx) && (state != IDLE);
  assign onehot      = 32'd1 << req_itag;

  assign hit = !empty && !tail_locked &&
               (src_q[tail_idx] == req_src_id) && (dst_q[tail_idx] == req_dst_id) &&
               (func_q[tail_idx] == req_func) && (tc_q[tail_idx] == req_tc) &&
               !vec_q[tail_idx][req_itag];

  assign req_ready   = hit || !full;
  assign accept      = req_valid && req_ready;
  assign pop         = (state == SEND_TXREQ) && cpl_txreq_ready;
  assign pending_cnt = tail_ptr - head_ptr;
  assign busy        = (state != IDLE) || !empty;
  assign cpl_cc      = 3'd2;

  // A coalesce into the head on the same edge it is latched must reach the completion too.
  assign head_vec = vec_q[head_idx] | ((accept && hit && (tail_idx == head_idx)) ? onehot : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else begin
      if (accept && !hit) tail_ptr <= tail_ptr + PTR_ONE;
      if (pop)            head_ptr <= head_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (hit) begin
        vec_q[tail_idx][req_itag] <= 1'b1;
      end else begin
        src_q[tail_ptr[AW-1:0]]  <= req_src_id;
        dst_q[tail_ptr[AW-1:0]]  <= req_dst_id;
        func_q[tail_ptr[AW-1:0]] <= req_func;
        tc_q[tail_ptr[AW-1:0]]   <= req_tc;
        vec_q[tail_ptr[AW-1:0]]  <= onehot;
      end
    end
  end

`ifdef PCIE_ATS_INVAL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] to_cnt;
  logic          timed_out;

  assign timed_out  = (state == FLUSH) && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign flush_done = flush_ack || timed_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != FLUSH)  to_cnt <= '0;
      else if (!timed_out) to_cnt <= to_cnt + TW'(1);
      if (timed_out && !flush_ack) timeout_err <= 1'b1;
    end
  end
`else
  assign flush_done  = flush_ack;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      flush_req       <= 1'b0;
      flush_func      <= '0;
      cpl_tx_valid    <= 1'b0;
      cpl_txreq_valid <= 1'b0;
      cpl_req_id      <= '0;
      cpl_dst_id      <= '0;
      cpl_itag_vec    <= '0;
      cpl_func        <= '0;
      cpl_tc          <= '0;
    end else begin
      unique case (state)
        IDLE: if (!empty) begin
          state        <= FLUSH;
          flush_req    <= 1'b1;
          flush_func   <= func_q[head_idx];
          cpl_req_id   <= dst_q[head_idx];
          cpl_dst_id   <= src_q[head_idx];
          cpl_itag_vec <= head_vec;
          cpl_func     <= func_q[head_idx];
          cpl_tc       <= tc_q[head_idx];
        end
        FLUSH: if (flush_done) begin
          flush_req    <= 1'b0;
          cpl_tx_valid <= 1'b1;
          state        <= SEND_TX;
        end
        SEND_TX: if (cpl_tx_ready) begin
          cpl_tx_valid    <= 1'b0;
          cpl_txreq_valid <= 1'b1;
          state           <= SEND_TXREQ;
        end
        SEND_TXREQ: if (cpl_txreq_ready) begin
          cpl_txreq_valid <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
